// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative data cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_REQ     = 3'd1,
    RD_REQ     = 3'd2,
    RD_WAIT    = 3'd3,
    FLUSH_SCAN = 3'd4,
    FLUSH_WB   = 3'd5
  } cache_state_t;

  function automatic int offset_bits(input int line_words, input int data_width);
    return $clog2(line_words * data_width / 8);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int num_sets,
                                  input int line_words, input int data_width);
    return addr_width - index_bits(num_sets) - offset_bits(line_words, data_width);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim choice for the ways of a single set.
module cache_lru #(
  parameter int NUM_WAYS = 2,
  localparam int AGE_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages,
  input  logic [NUM_WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]               access_way,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] new_ages,
  output logic [AGE_W-1:0]               victim_way
);

  logic [AGE_W-1:0] inv_way_s;
  logic [AGE_W-1:0] old_way_s;

  // Ages below the accessed one move up; downward scans favour the lowest index on ties
  always_comb begin
    new_ages  = ages;
    inv_way_s = {AGE_W{1'b0}};
    old_way_s = AGE_W'(NUM_WAYS - 1);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == access_way) begin
        new_ages[w] = {AGE_W{1'b0}};
      end else if (ages[w] < ages[access_way]) begin
        new_ages[w] = ages[w] + AGE_W'(1'b1);
      end else begin
        new_ages[w] = ages[w];
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      inv_way_s = valid[w] ? inv_way_s : AGE_W'(w);
      old_way_s = (ages[w] >= ages[old_way_s]) ? AGE_W'(w) : old_way_s;
    end
    victim_way = (&valid) ? old_way_s : inv_way_s;
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement, ready/valid line port to memory and a dirty-line flush walk.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             is_input_valid,
  input  logic                             mem_rw,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic                             is_ready,
  output logic                             is_output_valid,
  output logic                             is_hit,
  output logic [DATA_WIDTH-1:0]            dout,
  input  logic                             flush,
  output logic                             flush_done,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_write,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_req_data,
  input  logic                             mem_resp_valid,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_resp_data
);

  localparam int OFF_W  = offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam int IDX_W  = index_bits(NUM_SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, NUM_SETS, LINE_WORDS, DATA_WIDTH);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int CNT_W  = IDX_W + WAY_W;

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0) ||
      (NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0) ||
      (NUM_WAYS < 2) || ((NUM_WAYS & (NUM_WAYS - 1)) != 0) ||
      (LINE_WORDS < 1) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0) ||
      (TAG_W < 1)) begin : g_bad_params
    $error("set_assoc_cache: illegal geometry parameters");
  end

  cache_state_t state_r, state_nx_s;

  logic [NUM_WAYS-1:0]            valid_r [NUM_SETS];
  logic [NUM_WAYS-1:0]            dirty_r [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_r   [NUM_SETS];
  logic [TAG_W-1:0]               tag_r   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]              data_r  [NUM_SETS][NUM_WAYS];

  logic [WAY_W-1:0] victim_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             flush_done_r;

  logic [IDX_W-1:0]               idx_s;
  logic [TAG_W-1:0]               tag_s;
  logic [OFF_W-1:0]               word_s;
  logic                           hit_s;
  logic [WAY_W-1:0]               hit_way_s;
  logic [LINE_W-1:0]              hit_line_s;
  logic [NUM_WAYS-1:0][WAY_W-1:0] lru_ages_s;
  logic [WAY_W-1:0]               victim_s;
  logic [IDX_W-1:0]               fl_set_s;
  logic [WAY_W-1:0]               fl_way_s;
  logic                           fl_dirty_s;
  logic                           fl_last_s;

  assign idx_s      = addr[OFF_W +: IDX_W];
  assign tag_s      = addr[ADDR_WIDTH-1 -: TAG_W];
  assign word_s     = addr[OFF_W-1:0] >> BYTE_W;
  assign hit_line_s = data_r[idx_s][hit_way_s];
  assign fl_set_s   = flush_cnt_r[WAY_W +: IDX_W];
  assign fl_way_s   = flush_cnt_r[WAY_W-1:0];
  assign fl_dirty_s = dirty_r[fl_set_s][fl_way_s];
  assign fl_last_s  = (flush_cnt_r == {CNT_W{1'b1}});
  assign flush_done = flush_done_r;

  // Tags are unique within a set, so OR-ing the matching way index is exact
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_s     = hit_s | (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s));
      hit_way_s = hit_way_s | ((valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s))
                               ? WAY_W'(w) : {WAY_W{1'b0}});
    end
  end

  cache_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
    .ages       (age_r[idx_s]),
    .valid      (valid_r[idx_s]),
    .access_way (hit_way_s),
    .new_ages   (lru_ages_s),
    .victim_way (victim_s)
  );

  // Next-state and CPU/memory handshake outputs
  always_comb begin
    state_nx_s      = state_r;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = {DATA_WIDTH{1'b0}};
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = {ADDR_WIDTH{1'b0}};
    mem_req_data    = {LINE_W{1'b0}};
    case (state_r)
      IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid) begin
          if (hit_s) begin
            is_output_valid = 1'b1;
            is_hit          = 1'b1;
            dout            = hit_line_s[word_s*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            state_nx_s = (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) ? WB_REQ : RD_REQ;
          end
        end else begin
          is_output_valid = 1'b1;
          state_nx_s      = flush ? FLUSH_SCAN : IDLE;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_r[idx_s][victim_r], idx_s, {OFF_W{1'b0}}};
        mem_req_data  = data_r[idx_s][victim_r];
        state_nx_s    = mem_req_ready ? RD_REQ : WB_REQ;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_s, idx_s, {OFF_W{1'b0}}};
        state_nx_s    = mem_req_ready ? RD_WAIT : RD_REQ;
      end
      RD_WAIT: begin
        state_nx_s = mem_resp_valid ? IDLE : RD_WAIT;
      end
      FLUSH_SCAN: begin
        if (fl_dirty_s) begin
          state_nx_s = FLUSH_WB;
        end else begin
          state_nx_s = fl_last_s ? IDLE : FLUSH_SCAN;
        end
      end
      FLUSH_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_r[fl_set_s][fl_way_s], fl_set_s, {OFF_W{1'b0}}};
        mem_req_data  = data_r[fl_set_s][fl_way_s];
        state_nx_s    = mem_req_ready ? FLUSH_SCAN : FLUSH_WB;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control state: FSM, valid/dirty/age arrays, victim and flush walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      victim_r     <= {WAY_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
      flush_done_r <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= {NUM_WAYS{1'b0}};
        dirty_r[s] <= {NUM_WAYS{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_r[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      state_r      <= state_nx_s;
      flush_done_r <= (state_r == FLUSH_SCAN) && !fl_dirty_s && fl_last_s;
      case (state_r)
        IDLE: begin
          if (is_input_valid && hit_s) begin
            age_r[idx_s] <= lru_ages_s;
            if (mem_rw) begin
              dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
          end
          if (is_input_valid && !hit_s) begin
            victim_r <= victim_s;
          end
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            valid_r[idx_s][victim_r] <= 1'b1;
            dirty_r[idx_s][victim_r] <= 1'b0;
          end
        end
        FLUSH_SCAN: begin
          if (!fl_dirty_s) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
          end
        end
        FLUSH_WB: begin
          if (mem_req_ready) begin
            dirty_r[fl_set_s][fl_way_s] <= 1'b0;
          end
        end
        default: begin
          flush_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && is_input_valid && hit_s && mem_rw) begin
      data_r[idx_s][hit_way_s][word_s*DATA_WIDTH +: DATA_WIDTH] <= din;
    end
    if ((state_r == RD_WAIT) && mem_resp_valid) begin
      tag_r[idx_s][victim_r]  <= tag_s;
      data_r[idx_s][victim_r] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache at default geometry (offset [3:0], index [7:4]).
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic         mem_rw;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic         is_hit;
  logic [31:0]  dout;
  logic         flush;
  logic         flush_done;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  localparam logic [127:0] LINE_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};

  set_assoc_cache dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .mem_rw          (mem_rw),
    .addr            (addr),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .is_hit          (is_hit),
    .dout            (dout),
    .flush           (flush),
    .flush_done      (flush_done),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for one memory request, check it, accept it and answer reads with fill.
  task automatic mem_expect(input string tag, input logic w, input logic [31:0] a,
                            input logic [127:0] d, input logic [127:0] fill);
    int n = 0;
    while (!mem_req_valid && n < 40) begin
      tick();
      n++;
    end
    chk_b({tag, "_seen"}, mem_req_valid, 1'b1);
    chk_b({tag, "_write"}, mem_req_write, w);
    chk_w({tag, "_addr"}, mem_req_addr, a);
    if (w) chk_l({tag, "_data"}, mem_req_data, d);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if (!w) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = fill;
      tick();
      mem_resp_valid = 1'b0;
      #1;
    end
  endtask

  task automatic hit_access(input string tag, input logic rw, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_dout);
    is_input_valid = 1'b1;
    mem_rw = rw;
    addr   = a;
    din    = d;
    #1;
    chk_b({tag, "_hit"}, is_hit, 1'b1);
    if (!rw) chk_w({tag, "_dout"}, dout, exp_dout);
    chk_b({tag, "_nomem"}, mem_req_valid, 1'b0);
    tick();
  endtask

  task automatic clean_miss(input string tag, input logic rw, input logic [31:0] a,
                            input logic [31:0] d, input logic [127:0] fill,
                            input logic [31:0] exp_dout);
    is_input_valid = 1'b1;
    mem_rw = rw;
    addr   = a;
    din    = d;
    #1;
    chk_b({tag, "_miss_ov"}, is_output_valid, 1'b0);
    mem_expect({tag, "_rd"}, 1'b0, {a[31:4], 4'h0}, 128'h0, fill);
    chk_b({tag, "_fill_hit"}, is_hit, 1'b1);
    if (!rw) chk_w({tag, "_fill_dout"}, dout, exp_dout);
    tick();
  endtask

  task automatic wait_flush_done(input string tag);
    int n = 0;
    int extra = 0;
    while (!flush_done && n < 100) begin
      if (mem_req_valid) extra++;
      tick();
      n++;
    end
    chk_b({tag, "_done"}, flush_done, 1'b1);
    chk_w({tag, "_writes"}, 32'(extra), 32'h0);
    tick();
    chk_b({tag, "_pulse"}, flush_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    is_input_valid = 1'b0;
    mem_rw = 1'b0;
    addr = 32'h0;
    din = 32'h0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 128'h0;

    // reset values, during and after reset
    tick();
    tick();
    chk_b("rst_ready", is_ready, 1'b1);
    chk_b("rst_ov", is_output_valid, 1'b1);
    chk_b("rst_hit", is_hit, 1'b0);
    chk_w("rst_dout", dout, 32'h0);
    chk_b("rst_mreq", mem_req_valid, 1'b0);
    chk_b("rst_fdone", flush_done, 1'b0);
    reset = 1'b0;
    tick();
    chk_b("post_ready", is_ready, 1'b1);
    chk_b("post_ov", is_output_valid, 1'b1);
    chk_b("post_mreq", mem_req_valid, 1'b0);

    // cold read, then same-line hit
    clean_miss("cold100", 1'b0, 32'h100, 32'h0, LINE_A, 32'h11);
    hit_access("hit108", 1'b0, 32'h108, 32'h0, 32'h33);

    // write hit then read-back
    hit_access("wr104", 1'b1, 32'h104, 32'hDEAD, 32'h0);
    hit_access("rd104", 1'b0, 32'h104, 32'h0, 32'hDEAD);

    // 0x000 (write), 0x100 (write), 0x000, then 0x200 evicts dirty 0x100
    clean_miss("wr000", 1'b1, 32'h000, 32'hB0B0, LINE_B, 32'h0);
    hit_access("wr100", 1'b1, 32'h100, 32'h5555, 32'h0);
    hit_access("rd000", 1'b0, 32'h000, 32'h0, 32'hB0B0);
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr = 32'h200;
    #1;
    chk_b("ev200_miss_ov", is_output_valid, 1'b0);
    mem_expect("ev200_wb", 1'b1, 32'h100, {32'h44, 32'h33, 32'hDEAD, 32'h5555}, 128'h0);
    mem_expect("ev200_rd", 1'b0, 32'h200, 128'h0, LINE_C);
    chk_w("ev200_dout", dout, 32'hC0);
    tick();

    // memory holds ready low for 5 cycles on a clean miss
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr = 32'h520;
    #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_b("stall_valid", mem_req_valid, 1'b1);
      chk_w("stall_addr", mem_req_addr, 32'h520);
      chk_b("stall_write", mem_req_write, 1'b0);
      chk_b("stall_ov", is_output_valid, 1'b0);
      tick();
    end
    mem_expect("stall_rd", 1'b0, 32'h520, 128'h0, LINE_D);
    chk_w("stall_dout", dout, 32'hD0);
    tick();

    // dirty lines at 0x000 and 0x310, then two flushes
    clean_miss("wr310", 1'b1, 32'h310, 32'h7777, LINE_E, 32'h0);
    is_input_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_expect("fl_wb000", 1'b1, 32'h000, {32'hB3, 32'hB2, 32'hB1, 32'hB0B0}, 128'h0);
    mem_expect("fl_wb310", 1'b1, 32'h310, {32'hE3, 32'hE2, 32'hE1, 32'h7777}, 128'h0);
    wait_flush_done("flush1");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_flush_done("flush2");
    hit_access("post_flush_rd000", 1'b0, 32'h000, 32'h0, 32'hB0B0);

    // reset during RD_WAIT aborts, and the line misses again afterwards
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr = 32'h640;
    #1;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    is_input_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_b("abort_ready", is_ready, 1'b1);
    chk_b("abort_ov", is_output_valid, 1'b1);
    chk_b("abort_hit", is_hit, 1'b0);
    chk_b("abort_mreq", mem_req_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    clean_miss("re640", 1'b0, 32'h640, 32'h0, LINE_A, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache for the MEM stage of the pipelined core. It is the successor to the fixed-geometry data cache, with configurable sets, ways, line size and word width, true-LRU replacement, a ready/valid memory-side port and a software-visible flush. The CPU-side handshake is unchanged, so the MEM stall term stays `!is_ready || !is_output_valid`.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width. Must be a power of two and ≥ 8.
- `NUM_SETS`, 16: number of sets. Must be a power of two.
- `NUM_WAYS`, 2: associativity. Must be a power of two and ≥ 2.
- `LINE_WORDS`, 4: words per line. Must be a power of two.
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `is_input_valid`  in  1: CPU request present.
- `mem_rw`  in  1: 1 means write, 0 means read.
- `addr`  in  ADDR_WIDTH: byte address. Word-aligned; the low byte-offset bits are ignored.
- `din`  in  DATA_WIDTH: write data.
- `is_ready`  out  1: cache idle and able to take a request.
- `is_output_valid`  out  1: no pending result, or the current request is complete.
- `is_hit`  out  1: the current request hits.
- `dout`  out  DATA_WIDTH: read data.
- `flush`  in  1: request a write-back of all dirty lines.
- `flush_done`  out  1: one-cycle pulse when the flush completes.
- `mem_req_valid`  out  1: memory request valid.
- `mem_req_ready`  in  1: memory accepts the request.
- `mem_req_write`  out  1: 1 means line write-back, 0 means line read.
- `mem_req_addr`  out  ADDR_WIDTH: line-aligned address.
- `mem_req_data`  out  LINE_WORDS*DATA_WIDTH: write-back line. Word 0 occupies the LSBs.
- `mem_resp_valid`  in  1: one-cycle refill pulse.
- `mem_resp_data`  in  LINE_WORDS*DATA_WIDTH: refill line.

## Operation
- Address split: offset = log2(LINE_WORDS·DATA_WIDTH/8) bits, index = log2(NUM_SETS) bits, tag = the remaining bits.
- Per-line state: valid, dirty, tag, data. Per set and way: an age of log2(NUM_WAYS) bits.
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, FLUSH_SCAN, FLUSH_WB.
- IDLE with `is_input_valid`:
  - Lookup is combinational.
  - On a hit: `is_hit`=1 and `is_output_valid`=1 in the same cycle. A read drives `dout` with the addressed word. A write stores `din` and sets dirty at the edge. LRU is updated at the edge.
- IDLE with a miss:
  - `is_output_valid`=0.
  - Victim selection: the lowest-index invalid way if one exists; otherwise the way with the maximum age.
  - Next state is WB_REQ if the victim is dirty, otherwise RD_REQ.
- The requester holds `addr`, `din`, `mem_rw` and `is_input_valid` stable until `is_output_valid`=1.
- WB_REQ: drive a write-back of the victim's tag and index. When `mem_req_ready` is sampled high, the write is complete; go to RD_REQ.
- RD_REQ: drive a line read. When `mem_req_ready` is sampled high, go to RD_WAIT.
- RD_WAIT: on `mem_resp_valid`, install the line (valid=1, dirty=0, new tag) and return to IDLE. The lookup then hits and the request completes through the hit path.
- Request fields are stable while `mem_req_valid`=1. `mem_req_valid` never drops before acceptance.
- LRU update: the accessed way's age becomes 0. Ways whose age was below the accessed way's old age increment by 1. Ages within a set therefore stay a permutation.
- Flush:
  - `flush` is accepted in IDLE only when `is_input_valid`=0. If both are high, the request wins and `flush` must be re-asserted.
  - A counter walks all NUM_SETS·NUM_WAYS entries, one per cycle.
  - Each dirty entry goes through FLUSH_WB, which writes it back and clears dirty. Valid is kept.
  - After the last entry, `flush_done` pulses for one cycle and the FSM returns to IDLE.
- `is_ready`=1 only in IDLE.
- `is_output_valid`=1 in IDLE when there is no request or the request hits.
- `is_hit` and `dout` are 0 when there is no request or the request misses.

## Timing
- Reset (asynchronous): state=IDLE, all valid and dirty bits cleared, ages[w]=w, flush counter=0. Tag and data arrays are not cleared.
- Output values in reset and after release: `is_ready`=1, `is_output_valid`=1, `is_hit`=0, `dout`=0, `mem_req_valid`=0, `flush_done`=0.
- Hit latency: 0 cycles (combinational).
- Clean miss latency: 1 (RD_REQ entry) + ready wait + response wait + 1 cycles.
- A dirty miss adds the write-back handshake before the read.
- Reset in any state aborts the transaction. A `mem_resp_valid` outside RD_WAIT is ignored.
- A set whose ways are all valid and clean never generates write-back traffic.

## Structure
- Package `cache_pkg` holds: the state enum `cache_state_t`, and functions that derive offset, index and tag widths from the parameters.
- Elaboration-time parameter checks live in the top module.
- Sub-module `cache_lru`: combinational age update and victim selection for one set, parametrised by NUM_WAYS.

## Test plan
Defaults throughout: offset [3:0], index [7:4], tag [31:8].
- Cold read of 0x100; memory returns words 0x11, 0x22, 0x33, 0x44:
  - One read request at 0x100, then a hit with `dout`=0x11.
  - A following read of 0x108 hits in the same cycle with `dout`=0x33 and no memory traffic.
- Write 0xDEAD to 0x104 after the refill:
  - Immediate hit, no memory request.
  - A read of 0x104 returns 0xDEAD.
- Access 0x000 (write), 0x100 (write), 0x000, then 0x200:
  - The victim is line 0x100.
  - A write-back request at 0x100, carrying 0x100's data, is issued before the read at 0x200.
- Hold `mem_req_ready` low for 5 cycles during a miss:
  - `mem_req_valid`, `mem_req_addr` and `mem_req_write` stay constant.
  - `is_output_valid` stays 0 throughout.
- Dirty lines at 0x000 and 0x310, then `flush`:
  - Exactly two write requests (0x000, then 0x310) and one `flush_done` pulse.
  - A second flush produces zero writes.
- Assert `reset` during RD_WAIT:
  - Outputs return to their reset values immediately.
  - The same address then misses again.
